// File: rtl/ram_arb_pkg.sv
// Shared types and width helpers for the round-robin RAM arbiter.
// Widths are derived from the requester count and the burst cap.
package ram_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Owner/pointer width; a lone requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The burst counter must be able to hold MAX_BURST itself.
  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping modulo N. Kept separate so other arbiters can reuse it.
module rr_picker
  import ram_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  int cand;

  // Scan from the farthest offset down so the nearest request wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = int'(ptr) + off;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (req[cand]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter in front of a single-port RAM with locked bursts
// capped at MAX_BURST accesses per grant.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_REQ-1:0]       REQ,
  input  logic [NUM_REQ-1:0]       LOCK,
  input  logic [NUM_REQ-1:0]       WE_IN,
  input  logic [NUM_REQ*WIDTH-1:0] ADDRESS_IN,
  input  logic [NUM_REQ*WIDTH-1:0] WD_IN,
  output logic [NUM_REQ-1:0]       GNT,
  output logic [NUM_REQ-1:0]       RVALID,
  output logic [WIDTH-1:0]         RD_OUT,
  output logic                     RAM_WE,
  output logic [WIDTH-1:0]         RAM_ADDRESS,
  output logic [WIDTH-1:0]         RAM_WD,
  input  logic [WIDTH-1:0]         RAM_RD
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = cnt_width(MAX_BURST);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  arb_state_t       state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             access;

  rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (REQ),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Reset gates the access so a burst interrupted by RST never writes.
  assign access = (state == ARB_GRANT) && REQ[owner] && !RST;
  assign RD_OUT = RAM_RD;

  always_comb begin
    RAM_WE      = 1'b0;
    RAM_ADDRESS = '0;
    RAM_WD      = '0;
    RVALID      = '0;
    if (access) begin
      RAM_WE        = WE_IN[owner];
      RAM_ADDRESS   = ADDRESS_IN[int'(owner)*WIDTH +: WIDTH];
      RAM_WD        = WD_IN[int'(owner)*WIDTH +: WIDTH];
      RVALID[owner] = ~WE_IN[owner];
    end
  end

  // cnt holds accesses already done in this grant, so LAST_CNT marks the
  // access that reaches the cap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ARB_IDLE;
      GNT   <= '0;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            owner <= pick_idx;
            GNT   <= NUM_REQ'(1) << pick_idx;
            state <= ARB_GRANT;
          end else begin
            GNT <= '0;
          end
        end
        ARB_GRANT: begin
          if (!REQ[owner] || !LOCK[owner] || (cnt == LAST_CNT)) begin
            state <= ARB_IDLE;
            GNT   <= '0;
            cnt   <= '0;
            ptr   <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ARB_IDLE;
          GNT   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter with a RAM model and an access scoreboard; each
// requester works through its own transaction queue under the hold contract.
module tb_ram_arbiter;

  localparam int NUM_REQ   = 2;
  localparam int WIDTH     = 32;
  localparam int MAX_BURST = 16;

  typedef struct {
    logic        we;
    logic        lock;
    logic [31:0] addr;
    logic [31:0] data;
  } tx_t;

  typedef struct {
    int          req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  REQ = '0;
  logic [1:0]  LOCK = '0;
  logic [1:0]  WE_IN = '0;
  logic [63:0] ADDRESS_IN = '0;
  logic [63:0] WD_IN = '0;
  logic [1:0]  GNT;
  logic [1:0]  RVALID;
  logic [31:0] RD_OUT;
  logic        RAM_WE;
  logic [31:0] RAM_ADDRESS;
  logic [31:0] RAM_WD;
  logic [31:0] RAM_RD;

  logic [31:0] mem [0:1024];

  tx_t  txq0[$];
  tx_t  txq1[$];
  exp_t exp_q[$];
  logic rst_cmd = 1'b1;
  int   checks = 0;
  int   failures = 0;

  ram_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .REQ         (REQ),
    .LOCK        (LOCK),
    .WE_IN       (WE_IN),
    .ADDRESS_IN  (ADDRESS_IN),
    .WD_IN       (WD_IN),
    .GNT         (GNT),
    .RVALID      (RVALID),
    .RD_OUT      (RD_OUT),
    .RAM_WE      (RAM_WE),
    .RAM_ADDRESS (RAM_ADDRESS),
    .RAM_WD      (RAM_WD),
    .RAM_RD      (RAM_RD)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RAM_WE && (RAM_ADDRESS < 32'd1025)) mem[RAM_ADDRESS[10:0]] <= RAM_WD;
  end
  assign RAM_RD = (RAM_ADDRESS < 32'd1025) ? mem[RAM_ADDRESS[10:0]] : '0;

  task automatic push_tx(input int r, input logic we, input logic lock,
                         input logic [31:0] addr, input logic [31:0] data);
    tx_t t;
    t.we = we; t.lock = lock; t.addr = addr; t.data = data;
    if (r == 0) txq0.push_back(t);
    else txq1.push_back(t);
  endtask

  task automatic push_exp(input int r, input logic we,
                          input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    e.req = r; e.we = we; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  // One clock: drive queue fronts after the edge, observe on the falling edge.
  task automatic step();
    exp_t        e;
    logic [1:0]  eg;
    logic [31:0] act_data;
    @(posedge CLK);
    #1;
    RST = rst_cmd;
    if (txq0.size() != 0) begin
      REQ[0] = 1'b1; LOCK[0] = txq0[0].lock; WE_IN[0] = txq0[0].we;
      ADDRESS_IN[31:0] = txq0[0].addr; WD_IN[31:0] = txq0[0].data;
    end else begin
      REQ[0] = 1'b0; LOCK[0] = 1'b0; WE_IN[0] = 1'b0;
      ADDRESS_IN[31:0] = '0; WD_IN[31:0] = '0;
    end
    if (txq1.size() != 0) begin
      REQ[1] = 1'b1; LOCK[1] = txq1[0].lock; WE_IN[1] = txq1[0].we;
      ADDRESS_IN[63:32] = txq1[0].addr; WD_IN[63:32] = txq1[0].data;
    end else begin
      REQ[1] = 1'b0; LOCK[1] = 1'b0; WE_IN[1] = 1'b0;
      ADDRESS_IN[63:32] = '0; WD_IN[63:32] = '0;
    end
    @(negedge CLK);
    if ((RAM_WE !== 1'b0) || (RVALID !== 2'b00)) begin
      checks++;
      act_data = (RAM_WE === 1'b1) ? RAM_WD : RD_OUT;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_access at %0t: we=%b rvalid=%b addr=%h, required no access",
                 $time, RAM_WE, RVALID, RAM_ADDRESS);
      end else begin
        e = exp_q.pop_front();
        eg = '0;
        eg[e.req] = 1'b1;
        if ((RAM_WE !== e.we) || (GNT !== eg) || (RAM_ADDRESS !== e.addr) ||
            (act_data !== e.data) || (RVALID !== (e.we ? 2'b00 : eg))) begin
          failures++;
          $display("[TB] FAIL scoreboard at %0t: actual we=%b gnt=%b addr=%h data=%h rvalid=%b, required we=%b gnt=%b addr=%h data=%h rvalid=%b",
                   $time, RAM_WE, GNT, RAM_ADDRESS, act_data, RVALID,
                   e.we, eg, e.addr, e.data, (e.we ? 2'b00 : eg));
        end
      end
    end
    if (RST == 1'b0) begin
      if ((GNT[0] === 1'b1) && REQ[0] && (txq0.size() != 0)) void'(txq0.pop_front());
      if ((GNT[1] === 1'b1) && REQ[1] && (txq1.size() != 0)) void'(txq1.pop_front());
    end
  endtask

  task automatic do_reset();
    txq0.delete();
    txq1.delete();
    exp_q.delete();
    rst_cmd = 1'b1;
    step();
    step();
    rst_cmd = 1'b0;
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 80; i++) begin
      if ((txq0.size() == 0) && (txq1.size() == 0) && (exp_q.size() == 0) && (GNT === 2'b00)) break;
      step();
    end
  endtask

  task automatic test_reset();
    rst_cmd = 1'b1;
    push_tx(0, 1'b1, 1'b0, 32'd100, 32'h1111_1111);
    push_tx(1, 1'b1, 1'b0, 32'd101, 32'h2222_2222);
    push_exp(0, 1'b1, 32'd100, 32'h1111_1111);
    push_exp(1, 1'b1, 32'd101, 32'h2222_2222);
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ((GNT !== 2'b00) || (RAM_WE !== 1'b0) || (RVALID !== 2'b00) ||
          (RAM_ADDRESS !== 32'h0) || (RAM_WD !== 32'h0)) begin
        failures++;
        $display("[TB] FAIL reset_hold cycle %0d: gnt=%b we=%b rvalid=%b addr=%h wd=%h, required all zero",
                 k, GNT, RAM_WE, RVALID, RAM_ADDRESS, RAM_WD);
      end
    end
    rst_cmd = 1'b0;
    step();
    checks++;
    if (GNT !== 2'b00) begin
      failures++;
      $display("[TB] FAIL release_idle: gnt=%b, required 00", GNT);
    end
    step();
    checks++;
    if (GNT !== 2'b01) begin
      failures++;
      $display("[TB] FAIL first_grant: gnt=%b, required 01", GNT);
    end
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL reset_drain: %0d accesses outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_write_read();
    logic [1:0] exp_gnt [5];
    logic       exp_we  [5];
    logic [1:0] exp_rv  [5];
    exp_gnt = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    exp_we  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_rv  = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
    do_reset();
    push_tx(0, 1'b1, 1'b0, 32'd5, 32'hDEAD_BEEF);
    push_tx(1, 1'b0, 1'b0, 32'd5, 32'h0);
    push_exp(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
    push_exp(1, 1'b0, 32'd5, 32'hDEAD_BEEF);
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if ((GNT !== exp_gnt[k]) || (RAM_WE !== exp_we[k]) || (RVALID !== exp_rv[k])) begin
        failures++;
        $display("[TB] FAIL wr_seq cycle %0d: gnt=%b we=%b rvalid=%b, required gnt=%b we=%b rvalid=%b",
                 k, GNT, RAM_WE, RVALID, exp_gnt[k], exp_we[k], exp_rv[k]);
      end
      if (k == 3) begin
        checks++;
        if (RD_OUT !== 32'hDEAD_BEEF) begin
          failures++;
          $display("[TB] FAIL read_data: rd=%h, required deadbeef", RD_OUT);
        end
      end
    end
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL wr_drain: %0d accesses outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_contention();
    logic [1:0] eg;
    int         we_count;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push_tx(0, 1'b1, 1'b0, 32'd10, 32'hA0 + 32'(i));
      push_tx(1, 1'b1, 1'b0, 32'd20, 32'hB0 + 32'(i));
      push_exp(0, 1'b1, 32'd10, 32'hA0 + 32'(i));
      push_exp(1, 1'b1, 32'd20, 32'hB0 + 32'(i));
    end
    we_count = 0;
    for (int k = 0; k < 13; k++) begin
      step();
      if (RAM_WE === 1'b1) we_count++;
      eg = ((k % 4) == 1) ? 2'b01 : (((k % 4) == 3) ? 2'b10 : 2'b00);
      checks++;
      if (GNT !== eg) begin
        failures++;
        $display("[TB] FAIL contention_gnt cycle %0d: gnt=%b, required %b", k, GNT, eg);
      end
    end
    checks++;
    if (we_count != 6) begin
      failures++;
      $display("[TB] FAIL contention_writes: count=%0d, required 6", we_count);
    end
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL contention_drain: %0d accesses outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_burst_cap();
    logic [1:0]  gnt_h  [26];
    logic        we_h   [26];
    logic [31:0] addr_h [26];
    int          run;
    do_reset();
    for (int i = 0; i < 20; i++) push_tx(0, 1'b1, 1'b1, 32'(i), 32'h1000 + 32'(i));
    push_tx(1, 1'b1, 1'b0, 32'd500, 32'hBEEF_0001);
    for (int i = 0; i < 16; i++) push_exp(0, 1'b1, 32'(i), 32'h1000 + 32'(i));
    push_exp(1, 1'b1, 32'd500, 32'hBEEF_0001);
    for (int i = 16; i < 20; i++) push_exp(0, 1'b1, 32'(i), 32'h1000 + 32'(i));
    for (int k = 0; k < 26; k++) begin
      step();
      gnt_h[k] = GNT; we_h[k] = RAM_WE; addr_h[k] = RAM_ADDRESS;
    end
    run = 0;
    for (int k = 1; k < 26; k++) begin
      if ((gnt_h[k] === 2'b01) && (we_h[k] === 1'b1)) run++;
      else break;
    end
    checks++;
    if (run != 16) begin
      failures++;
      $display("[TB] FAIL burst_len: run=%0d, required 16", run);
    end
    checks++;
    if ((gnt_h[17] !== 2'b00) || (we_h[17] !== 1'b0)) begin
      failures++;
      $display("[TB] FAIL burst_bubble: gnt=%b we=%b, required 00/0", gnt_h[17], we_h[17]);
    end
    checks++;
    if ((gnt_h[18] !== 2'b10) || (we_h[18] !== 1'b1)) begin
      failures++;
      $display("[TB] FAIL burst_other: gnt=%b we=%b, required 10/1", gnt_h[18], we_h[18]);
    end
    checks++;
    if ((gnt_h[20] !== 2'b01) || (addr_h[20] !== 32'd16)) begin
      failures++;
      $display("[TB] FAIL burst_resume: gnt=%b addr=%h, required 01/00000010", gnt_h[20], addr_h[20]);
    end
    checks++;
    if ((gnt_h[24] !== 2'b01) || (we_h[24] !== 1'b0) || (gnt_h[25] !== 2'b00)) begin
      failures++;
      $display("[TB] FAIL burst_tail: gnt24=%b we24=%b gnt25=%b, required 01/0/00",
               gnt_h[24], we_h[24], gnt_h[25]);
    end
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL burst_drain: %0d accesses outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_early_release();
    logic [1:0] gnt_h [28];
    logic       we_h  [28];
    int         run;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push_tx(0, 1'b1, 1'b1, 32'd30 + 32'(i), 32'h300 + 32'(i));
      push_exp(0, 1'b1, 32'd30 + 32'(i), 32'h300 + 32'(i));
    end
    for (int k = 0; k < 28; k++) begin
      step();
      gnt_h[k] = GNT; we_h[k] = RAM_WE;
      if (k == 5) begin
        for (int i = 0; i < 17; i++) begin
          push_tx(0, 1'b1, 1'b1, 32'd40 + 32'(i), 32'h400 + 32'(i));
          push_exp(0, 1'b1, 32'd40 + 32'(i), 32'h400 + 32'(i));
        end
      end
    end
    checks++;
    if ((gnt_h[3] !== 2'b01) || (we_h[3] !== 1'b1)) begin
      failures++;
      $display("[TB] FAIL early_third: gnt=%b we=%b, required 01/1", gnt_h[3], we_h[3]);
    end
    checks++;
    if ((gnt_h[4] !== 2'b01) || (we_h[4] !== 1'b0)) begin
      failures++;
      $display("[TB] FAIL early_drop: gnt=%b we=%b, required 01/0", gnt_h[4], we_h[4]);
    end
    checks++;
    if (gnt_h[5] !== 2'b00) begin
      failures++;
      $display("[TB] FAIL early_idle: gnt=%b, required 00", gnt_h[5]);
    end
    run = 0;
    for (int k = 7; k < 28; k++) begin
      if ((gnt_h[k] === 2'b01) && (we_h[k] === 1'b1)) run++;
      else break;
    end
    checks++;
    if (run != 16) begin
      failures++;
      $display("[TB] FAIL early_count_restart: run=%0d, required 16", run);
    end
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL early_drain: %0d accesses outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    push_tx(0, 1'b1, 1'b0, 32'd7, 32'h1);
    push_exp(0, 1'b1, 32'd7, 32'h1);
    drain();
    push_tx(0, 1'b1, 1'b1, 32'd6, 32'hC0DE_0006);
    push_tx(0, 1'b1, 1'b1, 32'd7, 32'hBAD0_0007);
    push_exp(0, 1'b1, 32'd6, 32'hC0DE_0006);
    step();
    step();
    rst_cmd = 1'b1;
    step();
    checks++;
    if ((RAM_WE !== 1'b0) || (RAM_ADDRESS !== 32'h0) || (RAM_WD !== 32'h0) || (RVALID !== 2'b00)) begin
      failures++;
      $display("[TB] FAIL midrst_no_write: we=%b addr=%h wd=%h rvalid=%b, required 0/0/0/00",
               RAM_WE, RAM_ADDRESS, RAM_WD, RVALID);
    end
    rst_cmd = 1'b0;
    txq0.delete();
    step();
    checks++;
    if (GNT !== 2'b00) begin
      failures++;
      $display("[TB] FAIL midrst_gnt: gnt=%b, required 00", GNT);
    end
    push_tx(1, 1'b0, 1'b0, 32'd7, 32'h0);
    push_exp(1, 1'b0, 32'd7, 32'h1);
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL midrst_drain: %0d accesses outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_contention();
    test_burst_cap();
    test_early_release();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
